ram_dump_tx: RTL and testbench
==============================

Name: ram_dump_tx

Overview:
Reader side of the 256x256-bit result RAM that the PRNG path fills. On a start pulse it reads a run of consecutive RAM words and serializes each 256-bit word into 32 bytes, least-significant byte first, for the UART transmitter. Output uses a valid/ready byte handshake. It sits between the result RAM read port and the UART TX byte interface.

Parameters:
DATA_W, 256, RAM word width; must be a multiple of 8.
ADDR_W, 8, RAM address width (depth 2**ADDR_W).
NBYTES, DATA_W/8, bytes per word (derived; not overridden).

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle dump request; sampled only in IDLE
base_addr  in  ADDR_W  first RAM address, sampled with start
num_words  in  ADDR_W+1  word count 0..2**ADDR_W, sampled with start
ram_addr  out  ADDR_W  RAM read address (registered)
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_addr is presented (registered-output RAM)
tx_data  out  8  byte to UART TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts byte this cycle
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the run completes

Behaviour:
- Reset (async, any state): state=IDLE; ram_addr=0, tx_data=0, tx_valid=0, busy=0, done=0; shift register, word and byte counters cleared. An in-flight run is abandoned with no done pulse.
- Transfer: a byte transfers on a clk edge with tx_valid&&tx_ready. Once tx_valid is asserted, tx_valid and tx_data hold until the transfer. tx_ready may be high at any time, with no effect while tx_valid=0.
- FSM states: IDLE, WAIT, LOAD, SEND, FIN.
- IDLE: on start with num_words!=0: ram_addr<=base_addr, words_left<=num_words, state<=WAIT, busy<=1. On start with num_words==0: state<=FIN, busy<=1, no RAM read, no bytes.
- WAIT: one cycle for the RAM to register the address; ->LOAD.
- LOAD: shreg<=ram_rdata, byte_cnt<=0, tx_data<=ram_rdata[7:0], tx_valid<=1; ->SEND.
- SEND: on each transfer, shift shreg right by 8, tx_data<=next byte, byte_cnt++.
  - On the transfer with byte_cnt==NBYTES-1: tx_valid<=0 and words_left--.
  - If words_left was 1: ->FIN.
  - Otherwise ram_addr<=ram_addr+1 (mod 2**ADDR_W; 255 wraps to 0) and ->WAIT.
- FIN: done<=1 for one cycle, busy<=0; ->IDLE.
- Latency:
  - start sampled at edge T; tx_valid first high after edge T+2.
  - Inter-word gap: 2 cycles with tx_valid=0 between the last byte of word k and the first byte of word k+1.
  - With tx_ready tied high, each word takes 34 cycles.
- ram_addr is held constant throughout WAIT/LOAD/SEND of a word. The RAM write path must not target that address while busy; this is enforced at system level.
- start while busy is ignored, and so are base_addr and num_words changes while busy.
- num_words==2**ADDR_W dumps the whole RAM once, wrapping through address 0 when base_addr!=0.
- Total bytes emitted per run: exactly num_words*NBYTES.
- done and start in the same cycle: done is asserted only in FIN, so a new start is accepted no earlier than the cycle after FIN (IDLE). There is no overlap.

Test Plan:
1. RAM[5]=256'h1F1E...0100 (byte i = i), base=5, num=1, tx_ready=1 -> ram_addr=5; bytes 0x00,0x01..0x1F in order; tx_valid first high 2 cycles after start; done 1 cycle after the last byte; busy low afterward.
2. base=254, num=4, RAM[a]={32{a[7:0]}} -> ram_addr sequence 254,255,0,1; 128 bytes: 32x0xFE, 32x0xFF, 32x0x00, 32x0x01.
3. num=0 -> no tx_valid, busy high 1 cycle, done pulse 2 cycles after start.
4. Random tx_ready (~30% duty), num=3 -> tx_data/tx_valid stable while stalled; 96 bytes match a scoreboard; no dropped or duplicated bytes.
5. start pulsed again mid-run with different base/num -> ignored; the original run completes unchanged.
6. rst asserted during byte 10 of word 1 -> outputs at reset values immediately (async); no done; a fresh start base=0, num=1 afterward behaves as in test 1.

Source files
------------

// File: rtl/ram_dump_tx.sv
// Result-RAM reader: fetches a run of consecutive words and streams each one
// out as NBYTES bytes, LSB first, over a valid/ready byte handshake.
module ram_dump_tx #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int NBYTES = DATA_W / 8;
    localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, LOAD, SEND, FIN} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [ADDR_W:0]   words_left, words_left_n;
    logic [DATA_W-1:0] shreg, shreg_n, shreg_sh;
    logic [BC_W-1:0]   byte_cnt, byte_cnt_n;
    logic [7:0]        tx_data_n;
    logic              tx_valid_n, busy_n, done_n;

    assign shreg_sh = shreg >> 8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ram_addr   <= '0;
            words_left <= '0;
            shreg      <= '0;
            byte_cnt   <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            ram_addr   <= ram_addr_n;
            words_left <= words_left_n;
            shreg      <= shreg_n;
            byte_cnt   <= byte_cnt_n;
            tx_data    <= tx_data_n;
            tx_valid   <= tx_valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n      = state;
        ram_addr_n   = ram_addr;
        words_left_n = words_left;
        shreg_n      = shreg;
        byte_cnt_n   = byte_cnt;
        tx_data_n    = tx_data;
        tx_valid_n   = tx_valid;
        busy_n       = busy;
        done_n       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    busy_n = 1'b1;
                    // A zero-length run skips the RAM entirely and just reports done.
                    if (num_words != '0) begin
                        ram_addr_n   = base_addr;
                        words_left_n = num_words;
                        state_n      = WAIT;
                    end else begin
                        state_n = FIN;
                    end
                end
            end
            WAIT: state_n = LOAD;
            LOAD: begin
                shreg_n    = ram_rdata;
                byte_cnt_n = '0;
                tx_data_n  = ram_rdata[7:0];
                tx_valid_n = 1'b1;
                state_n    = SEND;
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    shreg_n    = shreg_sh;
                    tx_data_n  = shreg_sh[7:0];
                    byte_cnt_n = byte_cnt + 1'b1;
                    if (byte_cnt == BC_W'(NBYTES - 1)) begin
                        tx_valid_n   = 1'b0;
                        words_left_n = words_left - 1'b1;
                        if (words_left == (ADDR_W+1)'(1)) begin
                            state_n = FIN;
                        end else begin
                            ram_addr_n = ram_addr + 1'b1;
                            state_n    = WAIT;
                        end
                    end
                end
            end
            FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_dump_tx.sv
// Directed bench for ram_dump_tx: table of dump runs checked against a byte
// scoreboard built from the bench RAM image, plus reset/latency sequences.
module tb_ram_dump_tx;

    localparam int NB = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   base_addr = '0;
    logic [8:0]   num_words = '0;
    logic [7:0]   ram_addr;
    logic [255:0] ram_rdata;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         busy;
    logic         done;

    logic [255:0] mem [256];

    int checks = 0;
    int errors = 0;

    ram_dump_tx #(.DATA_W(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Registered-output RAM: data follows the address by one clock.
    always_ff @(posedge clk) ram_rdata <= mem[ram_addr];

    typedef struct {
        logic [7:0] base;
        logic [8:0] num;
        int         pct;
        int         inj;
        int         exp_total;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    // Results of the most recent run
    int         n_xfer, first_vld_cyc, last_cyc, done_cyc, n_done;
    int         n_unstable, n_bad_byte, n_bad_addr;
    logic [7:0] first_b, last_b;
    logic       busy_c1, busy_end;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input logic [7:0] b, input logic [8:0] n, input int pct, input int inj);
        int budget;
        int c;
        int w;
        int bi;
        logic         stall_prev;
        logic [7:0]   data_prev;
        logic [7:0]   exp_a;
        logic [255:0] word;
        budget = 100 + int'(n) * 200;
        n_xfer = 0; first_vld_cyc = -1; last_cyc = -1; done_cyc = -1; n_done = 0;
        n_unstable = 0; n_bad_byte = 0; n_bad_addr = 0;
        first_b = '0; last_b = '0; busy_c1 = 1'b0; busy_end = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = b; num_words = n;
        tx_ready = ($urandom_range(99, 0) < pct);
        c = 0;
        stall_prev = 1'b0;
        data_prev = '0;
        while (n_done == 0 && c < budget) begin
            @(negedge clk);
            c++;
            if (c == inj) begin
                start = 1'b1; base_addr = 8'd77; num_words = 9'd9;
            end else begin
                start = 1'b0;
            end
            tx_ready = ($urandom_range(99, 0) < pct);
            #1;
            if (c == 1) busy_c1 = busy;
            if (stall_prev && (!tx_valid || tx_data != data_prev)) n_unstable++;
            if (tx_valid && first_vld_cyc < 0) first_vld_cyc = c;
            if (done) begin
                n_done++;
                done_cyc = c;
                busy_end = busy;
            end
            if (tx_valid && tx_ready) begin
                w = n_xfer / NB;
                bi = n_xfer % NB;
                exp_a = b + 8'(w);
                word = mem[exp_a];
                if (tx_data != word[8*bi +: 8]) begin
                    n_bad_byte++;
                    if (n_bad_byte <= 4)
                        $display("  byte %0d: got %02h expected %02h", n_xfer, tx_data, word[8*bi +: 8]);
                end
                if (ram_addr != exp_a) n_bad_addr++;
                if (n_xfer == 0) first_b = tx_data;
                last_b = tx_data;
                last_cyc = c;
                n_xfer++;
            end
            stall_prev = tx_valid && !tx_ready;
            data_prev = tx_data;
        end
        start = 1'b0;
        tx_ready = 1'b0;
    endtask

    task automatic check_run(input vec_t v, input int idx);
        string p;
        p = $sformatf("run%0d", idx);
        check({p, "_done_count"}, n_done, 1);
        check({p, "_bytes"}, n_xfer, v.exp_total);
        check({p, "_bad_bytes"}, n_bad_byte, 0);
        check({p, "_bad_addr"}, n_bad_addr, 0);
        check({p, "_unstable"}, n_unstable, 0);
        check({p, "_busy_after_start"}, longint'(busy_c1), 1);
        check({p, "_busy_at_done"}, longint'(busy_end), 0);
        if (v.num != 0) begin
            check({p, "_first_byte"}, longint'(first_b), longint'(v.exp_first));
            check({p, "_last_byte"}, longint'(last_b), longint'(v.exp_last));
            check({p, "_first_valid_cyc"}, first_vld_cyc, 3);
            check({p, "_done_after_last"}, done_cyc - last_cyc, 2);
            if (v.pct == 100) check({p, "_last_xfer_cyc"}, last_cyc, 34 * int'(v.num));
        end else begin
            check({p, "_no_valid"}, first_vld_cyc, -1);
            check({p, "_done_cyc"}, done_cyc, 2);
        end
    endtask

    initial begin
        vec_t vecs[6];
        vec_t post;
        int   k;
        int   seen;
        int   stray;

        for (int a = 0; a < 256; a++)
            for (int i = 0; i < NB; i++)
                mem[a][8*i +: 8] = 8'(a);
        for (int i = 0; i < NB; i++) mem[5][8*i +: 8] = 8'(i);
        for (int a = 100; a <= 102; a++)
            for (int i = 0; i < NB; i++)
                mem[a][8*i +: 8] = 8'(a + 13 * i);

        vecs[0] = '{8'd5,   9'd1,   100, 0,  32,   8'h00, 8'h1F};
        vecs[1] = '{8'd254, 9'd4,   100, 0,  128,  8'hFE, 8'h01};
        vecs[2] = '{8'd0,   9'd0,   100, 0,  0,    8'h00, 8'h00};
        vecs[3] = '{8'd100, 9'd3,   30,  0,  96,   8'd100, 8'hF9};
        vecs[4] = '{8'd10,  9'd2,   100, 20, 64,   8'h0A, 8'h0B};
        vecs[5] = '{8'd200, 9'd256, 100, 0,  8192, 8'hC8, 8'hC7};

        // Reset state while rst is held
        #3;
        check("rst_tx_valid", longint'(tx_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_ram_addr", longint'(ram_addr), 0);
        check("rst_tx_data", longint'(tx_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].base, vecs[i].num, vecs[i].pct, vecs[i].inj);
            check_run(vecs[i], i);
            repeat (3) @(negedge clk);
        end

        // Async reset during byte 10 of word 1 of a base=1, num=3 run
        @(negedge clk);
        start = 1'b1; base_addr = 8'd1; num_words = 9'd3; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        k = 0;
        while (k < 200) begin
            #1;
            if (tx_valid && tx_ready) begin
                if (seen == 42) break;
                seen++;
            end
            @(negedge clk);
            k++;
        end
        check("rstmid_reached_byte42", k < 200 ? 1 : 0, 1);
        check("rstmid_addr_before", longint'(ram_addr), 2);
        check("rstmid_data_before", longint'(tx_data), 2);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_tx_valid", longint'(tx_valid), 0);
        check("rstmid_busy", longint'(busy), 0);
        check("rstmid_ram_addr", longint'(ram_addr), 0);
        check("rstmid_tx_data", longint'(tx_data), 0);
        check("rstmid_done", longint'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done || tx_valid || busy) stray++;
        end
        check("rstmid_quiet_after", stray, 0);

        post = '{8'd0, 9'd1, 100, 0, 32, 8'h00, 8'h00};
        run(post.base, post.num, post.pct, post.inj);
        check_run(post, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
